// File: rtl/fp_sqrt_seq.sv
// Sequential floating-point square root: restoring digit-by-digit core, one root bit per clock.
// Define FP_SQRT_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_sqrt_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_s,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sqrt,
    output logic [1:0]   flags
);

    localparam int N  = MAN_W + 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [EXP_W-1:0] BIAS     = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t              state;
    logic [EXP_W-1:0]    exp_r;
    logic [2*N-1:0]      x;
    logic [N-1:0]        q;
    logic [N-1:0]        rem;
    logic [CW-1:0]       cnt;

    logic                in_sign;
    logic [EXP_W-1:0]    in_exp;
    logic [MAN_W-1:0]    in_man;
    logic [EXP_W:0]      exp_sum;
    logic [N-1:0]        rad;
    logic                is_special;
    logic [W-1:0]        spec_res;
    logic [1:0]          spec_flags;

    assign in_sign = in_s[W-1];
    assign in_exp  = in_s[W-2:MAN_W];
    assign in_man  = in_s[MAN_W-1:0];

    // (E+B)>>1 is the result exponent; since B is odd, bit 0 of E+B is set exactly when E-B is odd.
    assign exp_sum = {1'b0, in_exp} + {1'b0, BIAS};
    assign rad     = exp_sum[0] ? {1'b1, in_man, 1'b0} : {2'b01, in_man};

    // Classify the incoming operand and form the result for all non-normal cases.
    always_comb begin
        is_special = 1'b1;
        spec_res   = QNAN;
        spec_flags = 2'b10;
        if (in_exp == {EXP_W{1'b0}}) begin
            spec_res   = {in_sign, {(W-1){1'b0}}};
            spec_flags = 2'b00;
        end else if (in_exp == EXP_ONES) begin
            if (in_man == {MAN_W{1'b0}}) begin
                if (in_sign) begin
                    spec_flags = 2'b10;
                end else begin
                    spec_res   = {1'b0, EXP_ONES, {MAN_W{1'b0}}};
                    spec_flags = 2'b00;
                end
            end else if (in_man[MAN_W-1]) begin
                spec_flags = 2'b00;
            end else begin
                spec_flags = 2'b10;
            end
        end else if (in_sign) begin
            spec_flags = 2'b10;
        end else begin
            is_special = 1'b0;
            spec_flags = 2'b00;
        end
    end

    logic [N+1:0]        rem_t;
    logic [N+1:0]        trial;
    logic [N+1:0]        rem_nxt;
    logic                ge;
    logic [N-2:0]        root_frac;
    logic [MAN_W-1:0]    man_t;
    logic                guard;
    logic                sticky;
    logic                inexact;
    logic [EXP_W-1:0]    res_exp;
    logic [MAN_W-1:0]    res_man;

    assign rem_t     = {rem, x[2*N-1 -: 2]};
    assign trial     = {q, 2'b01};
    assign ge        = (rem_t >= trial);
    assign rem_nxt   = ge ? (rem_t - trial) : rem_t;
    assign root_frac = {q[N-3:0], ge};
    assign man_t     = root_frac[N-2:1];
    assign guard     = root_frac[0];
    assign sticky    = |rem_nxt;
    assign inexact   = guard | sticky;

`ifdef FP_SQRT_RNE_EN
    logic                round_up;
    logic [MAN_W:0]      man_sum;

    assign round_up = guard & (sticky | man_t[0]);
    assign man_sum  = {1'b0, man_t} + {{MAN_W{1'b0}}, round_up};
    assign res_exp  = exp_r + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
    assign res_man  = man_sum[MAN_W-1:0];
`else
    assign res_exp  = exp_r;
    assign res_man  = man_t;
`endif

    // Control FSM, root iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sqrt      <= {W{1'b0}};
            flags     <= 2'b00;
            exp_r     <= {EXP_W{1'b0}};
            x         <= {(2*N){1'b0}};
            q         <= {N{1'b0}};
            rem       <= {N{1'b0}};
            cnt       <= {CW{1'b0}};
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_special) begin
                            sqrt      <= spec_res;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            exp_r <= exp_sum[EXP_W:1];
                            x     <= {rad, {N{1'b0}}};
                            q     <= {N{1'b0}};
                            rem   <= {N{1'b0}};
                            cnt   <= {CW{1'b0}};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    x   <= {x[2*N-3:0], 2'b00};
                    q   <= {q[N-2:0], ge};
                    rem <= rem_nxt[N-1:0];
                    cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt == CW'(N - 1)) begin
                        sqrt      <= {1'b0, res_exp, res_man};
                        flags     <= {1'b0, inexact};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
